// File: rtl/v16_pulse_generator.sv
// -----------------------------------------------------------------------------
// v16_pulse_generator
//
// Synthetic detector-pulse source for the v16 shaping filter. It produces an
// ADC-format sample stream made of a constant pedestal plus, for every
// accepted trigger, a linear rise over 2^RISE_SHIFT cycles followed by an
// exponential decay. A trigger accepted while a pulse is decaying stacks on
// top of the remaining tail (pile-up).
//
// Ports:
//   clk         clock
//   reset       asynchronous, active-low reset
//   trig_valid  request to start a pulse
//   trig_amp    pulse amplitude in ADC counts, sampled with trig_valid
//   trig_ready  trigger can be accepted this cycle (low only while rising)
//   adc_data    registered sample stream: BASELINE + pulse, clamped
//   busy        a pulse is in progress
//   pulse_cnt   number of accepted triggers, wraps
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no pulse, accumulator held at zero, waiting for a trigger
// S_RISE  | adding step to the accumulator once per cycle, triggers blocked
// S_DECAY | exponential tail; a new trigger restarts the rise on top of it
// -----------------------------------------------------------------------------
module v16_pulse_generator #(
    parameter int ADC_W       = 12,
    parameter int BASELINE    = 100,
    parameter int FRAC        = 8,
    parameter int RISE_SHIFT  = 2,
    parameter int DECAY_SHIFT = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig_valid,
    input  logic [ADC_W-1:0] trig_amp,
    output logic             trig_ready,
    output logic [ADC_W-1:0] adc_data,
    output logic             busy,
    output logic [CNT_W-1:0] pulse_cnt
);

    // One spare integer bit above ADC_W so pile-up can exceed full scale
    // before the output clamp kicks in.
    localparam int ACC_W    = ADC_W + FRAC + 1;
    localparam int INT_W    = ACC_W - FRAC;
    localparam int RC_W     = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
    localparam int RISE_LEN = 1 << RISE_SHIFT;

    localparam logic [RC_W-1:0]  RISE_LAST = RC_W'(RISE_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX   = '1;
    localparam logic [INT_W:0]   BASE_EXT  = (INT_W + 1)'(BASELINE);
    localparam logic [INT_W:0]   ADC_MAX   = (INT_W + 1)'((1 << ADC_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RISE,
        S_DECAY
    } state_t;

    state_t           state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [ACC_W-1:0] step_q,      step_d;
    logic [RC_W-1:0]  rise_cnt_q,  rise_cnt_d;
    logic [ADC_W-1:0] adc_data_q,  adc_data_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

    logic             accept;
    logic [ACC_W-1:0] step_new;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_sat;
    logic [ACC_W-1:0] acc_decay;
    logic             acc_int_zero;
    logic [INT_W:0]   adc_sum;

    assign trig_ready = (state_q != S_RISE);
    assign accept     = trig_valid & trig_ready;

    // Amplitude spread evenly across the rise: amp * 2^FRAC / 2^RISE_SHIFT.
    assign step_new = {{(ACC_W - ADC_W){1'b0}}, trig_amp} << (FRAC - RISE_SHIFT);

    assign acc_sum      = {1'b0, acc_q} + {1'b0, step_q};
    assign acc_sat      = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];
    assign acc_decay    = acc_q - (acc_q >> DECAY_SHIFT);
    assign acc_int_zero = (acc_q[ACC_W-1:FRAC] == '0);

    assign adc_sum = {1'b0, acc_q[ACC_W-1:FRAC]} + BASE_EXT;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        step_d      = step_q;
        rise_cnt_d  = rise_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        adc_data_d  = (adc_sum > ADC_MAX) ? ADC_MAX[ADC_W-1:0] : adc_sum[ADC_W-1:0];

        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                if (accept) begin
                    step_d      = step_new;
                    rise_cnt_d  = '0;
                    pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
                    state_d     = S_RISE;
                end
            end
            S_RISE: begin
                acc_d      = acc_sat;
                rise_cnt_d = rise_cnt_q + RC_W'(1);
                if (rise_cnt_q == RISE_LAST) begin
                    state_d = S_DECAY;
                end
            end
            S_DECAY: begin
                // A new trigger wins over decay so the tail is carried over
                // intact into the next rise.
                if (accept) begin
                    step_d      = step_new;
                    rise_cnt_d  = '0;
                    pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
                    state_d     = S_RISE;
                end else if (acc_int_zero) begin
                    acc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_decay;
                end
            end
            default: begin
                acc_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            step_q      <= '0;
            rise_cnt_q  <= '0;
            adc_data_q  <= ADC_W'(BASELINE);
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            rise_cnt_q  <= rise_cnt_d;
            adc_data_q  <= adc_data_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign adc_data  = adc_data_q;
    assign busy      = (state_q != S_IDLE);
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_v16_pulse_generator.sv
// -----------------------------------------------------------------------------
// tb_v16_pulse_generator
//
// Directed bench for v16_pulse_generator. Stimulus pushes expected values
// tagged with the clock-edge count at which they must hold; a monitor on the
// falling edge pops and compares whatever is due. Hand-computed sample values
// are pushed alongside a small reference model of the pulse shape.
// -----------------------------------------------------------------------------
module tb_v16_pulse_generator;

    localparam int K_ADC   = 0;
    localparam int K_READY = 1;
    localparam int K_BUSY  = 2;
    localparam int K_CNT   = 3;
    localparam int BIG     = 100000;
    localparam longint ACC_MAX = (longint'(1) << 21) - 1;

    logic        clk;
    logic        reset;
    logic        trig_valid;
    logic [11:0] trig_amp;
    logic        trig_ready;
    logic [11:0] adc_data;
    logic        busy;
    logic [15:0] pulse_cnt;

    typedef struct {
        int     cyc;
        int     kind;
        longint val;
    } exp_t;

    exp_t sb[$];
    exp_t keep[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ec      = 0;
    int   exp_cnt = 0;

    v16_pulse_generator #(
        .ADC_W      (12),
        .BASELINE   (100),
        .FRAC       (8),
        .RISE_SHIFT (2),
        .DECAY_SHIFT(4),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trig_valid(trig_valid),
        .trig_amp  (trig_amp),
        .trig_ready(trig_ready),
        .adc_data  (adc_data),
        .busy      (busy),
        .pulse_cnt (pulse_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) ec <= ec + 1;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got %0d edges expected fewer", ec);
        $fatal(1, "timeout");
    end

    function automatic string kname(input int k);
        case (k)
            K_ADC:   return "adc_data";
            K_READY: return "trig_ready";
            K_BUSY:  return "busy";
            default: return "pulse_cnt";
        endcase
    endfunction

    function automatic longint actual(input int k);
        case (k)
            K_ADC:   return longint'(adc_data);
            K_READY: return longint'(trig_ready);
            K_BUSY:  return longint'(busy);
            default: return longint'(pulse_cnt);
        endcase
    endfunction

    function automatic longint adc_of(input longint acc);
        longint v;
        v = 100 + (acc >> 8);
        return (v > 4095) ? 4095 : v;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic push(input int cyc, input int kind, input longint val);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Monitor: everything due at this edge count is compared and removed.
    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == ec) begin
                check($sformatf("%s@edge%0d", kname(sb[i].kind), sb[i].cyc),
                      actual(sb[i].kind), sb[i].val);
            end else if (sb[i].cyc < ec) begin
                check($sformatf("%s@edge%0d_missed", kname(sb[i].kind), sb[i].cyc),
                      -1, sb[i].val);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    // Reference pulse model. e0 is the edge count after the accepting edge;
    // acc0 is the accumulator carried into the pulse. Pushes expectations up
    // to k = last_k (status only for k < last_k, since a following accept
    // owns that edge) and returns the accumulator after edge last_k-1.
    task automatic model_pulse(input int e0, input int amp, input longint acc0,
                               input int last_k, output longint acc_out);
        longint acc;
        longint step;
        bit     done;
        acc     = acc0;
        step    = longint'(amp) << 6;
        done    = 1'b0;
        acc_out = acc0;
        push(e0, K_READY, 0);
        push(e0, K_BUSY, 1);
        for (int k = 1; k <= last_k; k++) begin
            push(e0 + k, K_ADC, adc_of(acc));
            if (done || k == last_k) begin
                acc_out = acc;
                break;
            end
            if (k <= 4) begin
                acc = acc + step;
                if (acc > ACC_MAX) acc = ACC_MAX;
            end else if ((acc >> 8) == 0) begin
                acc  = 0;
                done = 1'b1;
            end else begin
                acc = acc - (acc >> 4);
            end
            push(e0 + k, K_BUSY, done ? 0 : 1);
            push(e0 + k, K_READY, (k <= 3) ? 0 : 1);
        end
    endtask

    task automatic trigger(input int amp, output int e0);
        @(negedge clk);
        trig_valid = 1'b1;
        trig_amp   = 12'(amp);
        e0         = ec + 1;
    endtask

    task automatic release_trig(input int n);
        repeat (n) @(negedge clk);
        trig_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_pending", longint'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic idle_expect(input int n);
        for (int k = 1; k <= n; k++) begin
            push(ec + k, K_ADC, 100);
            push(ec + k, K_READY, 1);
            push(ec + k, K_BUSY, 0);
            push(ec + k, K_CNT, exp_cnt);
        end
    endtask

    task automatic pulse_400();
        int     e0;
        longint a;
        trigger(400, e0);
        exp_cnt++;
        push(e0, K_CNT, exp_cnt);
        push(e0 + 2, K_ADC, 200);
        push(e0 + 3, K_ADC, 300);
        push(e0 + 4, K_ADC, 400);
        push(e0 + 5, K_ADC, 500);
        push(e0 + 6, K_ADC, 475);
        push(e0 + 7, K_ADC, 451);
        model_pulse(e0, 400, 0, BIG, a);
        release_trig(1);
        drain();
    endtask

    initial begin
        int     e0;
        longint a1, a2, a3;

        reset      = 1'b0;
        trig_valid = 1'b0;
        trig_amp   = '0;

        // Reset held, then released with no trigger.
        repeat (3) @(negedge clk);
        idle_expect(1);
        @(negedge clk);
        reset = 1'b1;
        idle_expect(4);
        drain();

        // Single pulse, amplitude 400.
        pulse_400();

        // Amplitude 1: one sample at 101.
        trigger(1, e0);
        exp_cnt++;
        push(e0, K_CNT, exp_cnt);
        push(e0 + 4, K_ADC, 100);
        push(e0 + 5, K_ADC, 101);
        push(e0 + 6, K_ADC, 100);
        push(e0 + 5, K_BUSY, 1);
        push(e0 + 6, K_BUSY, 0);
        model_pulse(e0, 1, 0, BIG, a1);
        release_trig(1);
        drain();

        // Amplitude 0: counted, flat rise, idle on the first decay edge.
        trigger(0, e0);
        exp_cnt++;
        push(e0, K_CNT, exp_cnt);
        push(e0 + 3, K_ADC, 100);
        push(e0 + 4, K_BUSY, 1);
        push(e0 + 5, K_BUSY, 0);
        model_pulse(e0, 0, 0, BIG, a1);
        release_trig(1);
        drain();

        // Pile-up: trigger held high, re-accepted on the first decay edge.
        trigger(400, e0);
        exp_cnt++;
        push(e0, K_CNT, exp_cnt);
        exp_cnt++;
        push(e0 + 5, K_CNT, exp_cnt);
        push(e0 + 2, K_READY, 0);
        push(e0 + 4, K_READY, 1);
        push(e0 + 7, K_READY, 0);
        push(e0 + 9, K_READY, 1);
        push(e0 + 5, K_ADC, 500);
        push(e0 + 10, K_ADC, 900);
        model_pulse(e0, 400, 0, 5, a1);
        model_pulse(e0 + 5, 400, a1, BIG, a2);
        release_trig(6);
        drain();

        // Full-scale amplitude: output clamps for one sample.
        trigger(4095, e0);
        exp_cnt++;
        push(e0, K_CNT, exp_cnt);
        push(e0 + 4, K_ADC, 3171);
        push(e0 + 5, K_ADC, 4095);
        push(e0 + 6, K_ADC, 3939);
        model_pulse(e0, 4095, 0, BIG, a1);
        release_trig(1);
        drain();

        // Triple full-scale pile-up: accumulator saturates, never wraps.
        trigger(4095, e0);
        exp_cnt++;
        push(e0, K_CNT, exp_cnt);
        exp_cnt++;
        push(e0 + 5, K_CNT, exp_cnt);
        exp_cnt++;
        push(e0 + 10, K_CNT, exp_cnt);
        push(e0 + 10, K_ADC, 4095);
        push(e0 + 15, K_ADC, 4095);
        model_pulse(e0, 4095, 0, 5, a1);
        model_pulse(e0 + 5, 4095, a1, 5, a2);
        model_pulse(e0 + 10, 4095, a2, BIG, a3);
        release_trig(11);
        drain();

        // Reset during decay (acc near 290), then a clean pulse.
        trigger(400, e0);
        exp_cnt++;
        push(e0, K_CNT, exp_cnt);
        model_pulse(e0, 400, 0, 8, a1);
        release_trig(1);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        exp_cnt = 0;
        check("reset_async_adc", longint'(adc_data), 100);
        check("reset_async_busy", longint'(busy), 0);
        check("reset_async_ready", longint'(trig_ready), 1);
        check("reset_async_cnt", longint'(pulse_cnt), 0);
        idle_expect(2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle_expect(3);
        drain();
        pulse_400();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/v16_pulse_generator.md
Name: v16_pulse_generator

Overview:
Synthetic detector-pulse source that emits an ADC-format sample stream: baseline plus a linear-rise, exponential-decay pulse per accepted trigger. It drives the input_data port of the v16 shaping filter in place of a real ADC, for bench and on-chip self-test. It is the transmitter side of the filter's sample interface. Pile-up is supported: a trigger accepted during decay stacks on the residual tail.

Parameters:
ADC_W, 12, width of output sample (unsigned)
BASELINE, 100, constant pedestal added to every sample
FRAC, 8, fractional bits of internal accumulator
RISE_SHIFT, 2, rise length = 2^RISE_SHIFT cycles (RISE_SHIFT <= FRAC)
DECAY_SHIFT, 4, per-cycle decay acc -= acc>>>DECAY_SHIFT (tau ~ 2^DECAY_SHIFT cycles; DECAY_SHIFT < FRAC)
CNT_W, 16, width of pulse counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
trig_valid  in  1  request to start a pulse
trig_amp  in  ADC_W  pulse amplitude in ADC counts, sampled with trig_valid
trig_ready  out  1  trigger can be accepted this cycle
adc_data  out  ADC_W  registered sample stream to filter
busy  out  1  pulse in progress (state != IDLE)
pulse_cnt  out  CNT_W  number of accepted triggers, wraps

Behaviour:
- Reset (reset=0, async): state=IDLE, acc=0, rise_cnt=0, step=0, adc_data=BASELINE, pulse_cnt=0. Reset mid-pulse aborts the pulse; no residual tail after release.
- acc: unsigned, ADC_W+FRAC+1 bits, fixed point with FRAC fraction bits; saturates at all-ones, never wraps.
- trig_ready = (state != RISE), combinational. Accept = trig_valid & trig_ready.
- States:
  - IDLE: on accept: step <= trig_amp << (FRAC-RISE_SHIFT), rise_cnt <= 0, pulse_cnt++, go RISE. acc stays 0.
  - RISE: each edge acc <= sat(acc+step), rise_cnt++. On the edge where rise_cnt == 2^RISE_SHIFT-1, go DECAY. Triggers are blocked.
  - DECAY: default acc <= acc - (acc >> DECAY_SHIFT).
    - Accept has priority: no decay that edge; latch new step, rise_cnt <= 0, pulse_cnt++, go RISE. acc carries over (pile-up).
    - Otherwise, if integer part acc[..FRAC] == 0: acc <= 0, go IDLE.
- Output: adc_data <= min(BASELINE + (acc >> FRAC), 2^ADC_W-1), registered. adc_data reflects acc one edge late: one cycle latency from the acc update.
- Timing from accept at edge E0:
  - acc steps on E1..E2^RISE_SHIFT.
  - First adc_data change at E2.
- trig_amp = 0: still accepted and counted; produces 2^RISE_SHIFT flat rise cycles, then returns to IDLE on the first DECAY edge.
- pulse_cnt wraps from 2^CNT_W-1 to 0.
- busy is derived from the state register only.

Test Plan (defaults):
1. Reset held, then released, no trigger → adc_data=100 constantly, trig_ready=1, busy=0, pulse_cnt=0.
2. trig_amp=400 accepted at E0 → adc_data after E2..E5 = 200, 300, 400, 500. After E6 = 475, after E7 = 451. Output decays monotonically to 100, then busy=0.
3. trig_amp=1 → acc reaches 1.0 after E4. Next edge gives 0.9375 (integer part 0), then IDLE with acc=0. adc_data shows 101 for exactly one sample, then 100.
4. trig_valid held high with amp=400 across pulse → trig_ready=0 during the 4 RISE cycles. Re-accepted on the first DECAY edge; peak stacks to 900 (100+400+400), pulse_cnt increments per accept.
5. trig_amp=4095 → adc_data clamps at 4095 during peak with no wrap, then decays below 4095.
6. reset asserted during DECAY at acc≈300 → adc_data=100 immediately (async), state IDLE, pulse_cnt=0. First post-release trigger behaves exactly as scenario 2.
